// File: rtl/regw_arbiter_if.sv
// Writeback bus between the two requesters, the register file write port and
// the hazard-check read addresses of the control unit.
interface regw_arbiter_if;
  // requester 0 (main datapath writeback)
  logic        v0;
  logic [4:0]  a0;
  logic [31:0] d0;
  logic        rdy0;
  // requester 1 (slow unit writeback)
  logic        v1;
  logic [4:0]  a1;
  logic [31:0] d1;
  logic        rdy1;
  // register file write port
  logic [4:0]  wr;
  logic [31:0] wdata;
  logic        regw;
  // hazard check
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic        hit1;
  logic        hit2;

  // Requester / control side
  modport master (
    output v0, a0, d0, v1, a1, d1, r1, r2,
    input  rdy0, rdy1, wr, wdata, regw, hit1, hit2
  );

  // Arbiter side
  modport slave (
    input  v0, a0, d0, v1, a1, d1, r1, r2,
    output rdy0, rdy1, wr, wdata, regw, hit1, hit2
  );
endinterface

// File: rtl/regw_arbiter.sv
// Register file write-port arbiter: two one-entry holding buffers drained by a
// round-robin or fixed-priority (with starvation guard) arbiter into a
// registered write-port stage, plus read-after-write pending-hit flags.
module regw_arbiter #(
  parameter int PRIO_MODE = 0,  // 0 = round-robin, 1 = req0 priority
  parameter int MAX_WAIT  = 4   // fixed mode: force-grant threshold (1..15)
) (
  input logic           clk,
  input logic           rst_n,
  regw_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  // per-requester views of the bus
  logic        vin [2];
  logic [4:0]  ain [2];
  logic [31:0] din [2];

  // holding buffers
  logic        full_q [2];
  logic        full_d [2];
  logic [4:0]  abuf_q [2];
  logic [4:0]  abuf_d [2];
  logic [31:0] dbuf_q [2];
  logic [31:0] dbuf_d [2];

  // arbitration state
  logic        older1_q, older1_d;  // 1: buf1 entry was captured before buf0's
  logic        rr_q, rr_d;          // round-robin pointer, 0 = req0
  logic [3:0]  wait_q, wait_d;      // cycles buf1 has waited (fixed mode)

  // output stage
  logic [4:0]  wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        regw_q, regw_d;

  logic [1:0]  gnt;
  logic [1:0]  rdy;
  logic [1:0]  cap;
  logic [1:0]  keep;
  logic [4:0]  gaddr;
  logic [31:0] gdata;

  assign vin[0] = bus.v0;
  assign ain[0] = bus.a0;
  assign din[0] = bus.d0;
  assign vin[1] = bus.v1;
  assign ain[1] = bus.a1;
  assign din[1] = bus.d1;

  // Grant among full buffers; same-address pairs always retire oldest first
  always_comb begin
    gnt = 2'b00;
    if (full_q[0] && !full_q[1]) begin
      gnt = 2'b01;
    end else if (!full_q[0] && full_q[1]) begin
      gnt = 2'b10;
    end else if (full_q[0] && full_q[1]) begin
      if (abuf_q[0] == abuf_q[1]) begin
        gnt = older1_q ? 2'b10 : 2'b01;
      end else if (PRIO_MODE == 0) begin
        gnt = rr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = (wait_q == MAX_WAIT_L) ? 2'b10 : 2'b01;
      end
    end
  end

  // Per-buffer handshake and refill; a buffer may refill on the cycle it drains
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    assign rdy[gi]  = rst_n & (~full_q[gi] | gnt[gi]);
    assign cap[gi]  = vin[gi] & rdy[gi];
    assign keep[gi] = full_q[gi] & ~gnt[gi];

    // Next buffer contents: capture new request or hold the waiting one
    always_comb begin
      full_d[gi] = cap[gi] | keep[gi];
      abuf_d[gi] = cap[gi] ? ain[gi] : abuf_q[gi];
      dbuf_d[gi] = cap[gi] ? din[gi] : dbuf_q[gi];
    end

    // Buffer registers; reset discards anything held
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        full_q[gi] <= 1'b0;
        abuf_q[gi] <= 5'd0;
        dbuf_q[gi] <= 32'd0;
      end else begin
        full_q[gi] <= full_d[gi];
        abuf_q[gi] <= abuf_d[gi];
        dbuf_q[gi] <= dbuf_d[gi];
      end
    end
  end

  // Age bit, round-robin pointer and starvation counter updates
  always_comb begin
    // age: whichever entry stays while the other is newly captured is older;
    // simultaneous capture counts req0 as older
    older1_d = 1'b0;
    if (keep[1] && cap[0]) begin
      older1_d = 1'b1;
    end else if (keep[0] && cap[1]) begin
      older1_d = 1'b0;
    end else if (keep[0] && keep[1]) begin
      older1_d = older1_q;
    end

    rr_d = rr_q;
    if (gnt[0]) begin
      rr_d = 1'b1;
    end else if (gnt[1]) begin
      rr_d = 1'b0;
    end

    wait_d = 4'd0;
    if (PRIO_MODE != 0) begin
      if (gnt[1]) begin
        wait_d = 4'd0;
      end else if (full_q[1] && (wait_q != 4'd15)) begin
        wait_d = wait_q + 4'd1;
      end else begin
        wait_d = wait_q;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      older1_q <= 1'b0;
      rr_q     <= 1'b0;
      wait_q   <= 4'd0;
    end else begin
      older1_q <= older1_d;
      rr_q     <= rr_d;
      wait_q   <= wait_d;
    end
  end

  // Output stage next state: writes to register 0 are dropped here, and the
  // address/data lines keep their last real write while idle
  always_comb begin
    gaddr   = gnt[1] ? abuf_q[1] : abuf_q[0];
    gdata   = gnt[1] ? dbuf_q[1] : dbuf_q[0];
    regw_d  = (|gnt) && (gaddr != 5'd0);
    wr_d    = regw_d ? gaddr : wr_q;
    wdata_d = regw_d ? gdata : wdata_q;
  end

  // Registered write-port driver
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= 5'd0;
      wdata_q <= 32'd0;
      regw_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      regw_q  <= regw_d;
    end
  end

  // Pending-write hazard flags from current state only; register 0 never hits
  always_comb begin
    bus.hit1 = (bus.r1 != 5'd0) &&
               ((full_q[0] && (abuf_q[0] == bus.r1)) ||
                (full_q[1] && (abuf_q[1] == bus.r1)) ||
                (regw_q && (wr_q == bus.r1)));
    bus.hit2 = (bus.r2 != 5'd0) &&
               ((full_q[0] && (abuf_q[0] == bus.r2)) ||
                (full_q[1] && (abuf_q[1] == bus.r2)) ||
                (regw_q && (wr_q == bus.r2)));
  end

  assign bus.rdy0  = rdy[0];
  assign bus.rdy1  = rdy[1];
  assign bus.wr    = wr_q;
  assign bus.wdata = wdata_q;
  assign bus.regw  = regw_q;

endmodule

// File: tb/tb_regw_arbiter.sv
// Scoreboard bench for regw_arbiter: one round-robin and one fixed-priority
// instance; expected writes are queued with the stimulus and popped by
// per-instance monitors whenever regw is seen.
module tb_regw_arbiter;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  regw_arbiter_if bus_rr ();
  regw_arbiter_if bus_fx ();

  regw_arbiter #(.PRIO_MODE(0), .MAX_WAIT(4)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr.slave)
  );

  regw_arbiter #(.PRIO_MODE(1), .MAX_WAIT(4)) u_fx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fx.slave)
  );

  logic [36:0] q_rr [$];
  logic [36:0] q_fx [$];
  int          fx_w7_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin instance monitor
  always @(negedge clk) begin
    if (bus_rr.regw === 1'b1) begin
      checks++;
      if (q_rr.size() == 0) begin
        errors++;
        $display("FAIL rr_unexpected_write: got wr=%0d wdata=%0h expected none", bus_rr.wr, bus_rr.wdata);
      end else begin
        logic [36:0] e;
        e = q_rr.pop_front();
        if ({bus_rr.wr, bus_rr.wdata} !== e) begin
          errors++;
          $display("FAIL rr_write: got wr=%0d wdata=%0h expected wr=%0d wdata=%0h",
                   bus_rr.wr, bus_rr.wdata, e[36:32], e[31:0]);
        end else begin
          $display("rr write wr=%0d wdata=%0h cycle %0d", bus_rr.wr, bus_rr.wdata, cyc);
        end
      end
    end
  end

  // Fixed-priority instance monitor
  always @(negedge clk) begin
    if (bus_fx.regw === 1'b1) begin
      checks++;
      if (bus_fx.wr == 5'd7) fx_w7_cyc = cyc;
      if (q_fx.size() == 0) begin
        errors++;
        $display("FAIL fx_unexpected_write: got wr=%0d wdata=%0h expected none", bus_fx.wr, bus_fx.wdata);
      end else begin
        logic [36:0] e;
        e = q_fx.pop_front();
        if ({bus_fx.wr, bus_fx.wdata} !== e) begin
          errors++;
          $display("FAIL fx_write: got wr=%0d wdata=%0h expected wr=%0d wdata=%0h",
                   bus_fx.wr, bus_fx.wdata, e[36:32], e[31:0]);
        end else begin
          $display("fx write wr=%0d wdata=%0h cycle %0d", bus_fx.wr, bus_fx.wdata, cyc);
        end
      end
    end
  end

  task automatic drive(input bit fx, input bit port, input bit v, input logic [4:0] a, input logic [31:0] d);
    if (!fx && !port) begin bus_rr.v0 = v; bus_rr.a0 = a; bus_rr.d0 = d; end
    if (!fx &&  port) begin bus_rr.v1 = v; bus_rr.a1 = a; bus_rr.d1 = d; end
    if ( fx && !port) begin bus_fx.v0 = v; bus_fx.a0 = a; bus_fx.d0 = d; end
    if ( fx &&  port) begin bus_fx.v1 = v; bus_fx.a1 = a; bus_fx.d1 = d; end
  endtask

  function automatic bit rdy_of(input bit fx, input bit port);
    if (fx) return port ? bus_fx.rdy1 : bus_fx.rdy0;
    return port ? bus_rr.rdy1 : bus_rr.rdy0;
  endfunction

  // Offer one write; acc returns the cycle whose closing edge accepted it
  task automatic send(input bit fx, input bit port, input logic [4:0] a, input logic [31:0] d,
                      output int acc);
    int k;
    k = 0;
    acc = -1;
    drive(fx, port, 1'b1, a, d);
    while (acc < 0 && k < 20) begin
      @(negedge clk);
      if (rdy_of(fx, port)) acc = cyc;
      k++;
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no ready expected ready (fx=%0d port=%0d)", fx, port);
    end
    @(posedge clk);
    #1;
    drive(fx, port, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q_rr.size() != 0 || q_fx.size() != 0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("drain_rr", q_rr.size(), 0);
    chk("drain_fx", q_fx.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rdy0", bus_rr.rdy0, 1'b0);
    chk("rst_rdy1", bus_fx.rdy1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_rr.delete();
    q_fx.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int acc0, acc1, acc7, n;
    checks = 0;
    errors = 0;
    cyc = 0;
    fx_w7_cyc = -1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0);
    bus_rr.r1 = 0; bus_rr.r2 = 0; bus_fx.r1 = 0; bus_fx.r2 = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    do_reset();
    @(negedge clk);
    chk("reset_wr", bus_rr.wr, 5'd0);
    chk("reset_wdata", bus_rr.wdata, 32'd0);
    chk("reset_regw", bus_rr.regw, 1'b0);
    chk("reset_rdy0", bus_rr.rdy0, 1'b1);
    chk("reset_rdy1", bus_rr.rdy1, 1'b1);

    // single write, latency and hazard window
    @(posedge clk); #1;
    bus_rr.r1 = 5'd1;
    q_rr.push_back({5'd1, 32'h0000fff0});
    send(0, 0, 5'd1, 32'h0000fff0, acc0);
    n = acc0;
    @(negedge clk);
    chk("t1_hit_buf", bus_rr.hit1, 1'b1);
    chk("t1_regw_early", bus_rr.regw, 1'b0);
    @(negedge clk);
    chk("t1_lat", cyc - n, 2);
    chk("t1_regw", bus_rr.regw, 1'b1);
    chk("t1_hit_out", bus_rr.hit1, 1'b1);
    @(negedge clk);
    chk("t1_regw_off", bus_rr.regw, 1'b0);
    chk("t1_hit_off", bus_rr.hit1, 1'b0);
    chk("t1_wr_hold", bus_rr.wr, 5'd1);
    drain();

    // concurrent requests, round-robin
    do_reset();
    q_rr.push_back({5'd2, 32'h22});
    q_rr.push_back({5'd3, 32'h33});
    fork
      send(0, 0, 5'd2, 32'h22, acc0);
      send(0, 1, 5'd3, 32'h33, acc1);
    join
    chk("t2_same_accept", acc1, acc0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_first_regw", bus_rr.regw, 1'b1);
    chk("t2_first_wr", bus_rr.wr, 5'd2);
    @(negedge clk);
    chk("t2_second_regw", bus_rr.regw, 1'b1);
    chk("t2_second_wr", bus_rr.wr, 5'd3);
    @(negedge clk);
    chk("t2_idle", bus_rr.regw, 1'b0);
    drain();

    // same address, req1 first then req0 (round-robin)
    do_reset();
    q_rr.push_back({5'd5, 32'hAA});
    q_rr.push_back({5'd5, 32'hBB});
    send(0, 1, 5'd5, 32'hAA, acc1);
    send(0, 0, 5'd5, 32'hBB, acc0);
    chk("t3_back2back", acc0 - acc1, 1);
    drain();

    // same address with both buffers full, buf1 older (fixed mode)
    do_reset();
    q_fx.push_back({5'd9, 32'h99});
    q_fx.push_back({5'd5, 32'hAA});
    q_fx.push_back({5'd5, 32'hBB});
    fork
      begin
        send(1, 0, 5'd9, 32'h99, acc0);
        send(1, 0, 5'd5, 32'hBB, acc0);
      end
      send(1, 1, 5'd5, 32'hAA, acc1);
    join
    drain();

    // fixed-priority starvation guard
    do_reset();
    for (int k = 0; k < 5; k++) q_fx.push_back({5'(10 + k), 32'(100 + k)});
    q_fx.push_back({5'd7, 32'h77});
    for (int k = 5; k < 8; k++) q_fx.push_back({5'(10 + k), 32'(100 + k)});
    fx_w7_cyc = -1;
    fork
      begin
        int a;
        for (int k = 0; k < 8; k++) send(1, 0, 5'(10 + k), 32'(100 + k), a);
      end
      begin
        @(posedge clk); #1;
        send(1, 1, 5'd7, 32'h77, acc7);
      end
    join
    drain();
    chk("t4_starve_latency", fx_w7_cyc - acc7, 6);

    // register 0 write is accepted but never written or flagged
    do_reset();
    bus_rr.r1 = 5'd0;
    send(0, 0, 5'd0, 32'hFFFFFFFF, acc0);
    chk("t5_accepted", acc0 >= 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_no_regw", bus_rr.regw, 1'b0);
      chk("t5_no_hit", bus_rr.hit1, 1'b0);
    end
    drain();

    // reset with both buffers full discards them
    do_reset();
    bus_rr.r1 = 5'd20;
    bus_rr.r2 = 5'd21;
    fork
      send(0, 0, 5'd20, 32'h2020, acc0);
      send(0, 1, 5'd21, 32'h2121, acc1);
    join
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_hit1_before", bus_rr.hit1, 1'b1);
    chk("t6_hit2_before", bus_rr.hit2, 1'b1);
    chk("t6_rdy0_in_reset", bus_rr.rdy0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_regw", bus_rr.regw, 1'b0);
      chk("t6_hit1", bus_rr.hit1, 1'b0);
      chk("t6_hit2", bus_rr.hit2, 1'b0);
      chk("t6_rdy", {bus_rr.rdy0, bus_rr.rdy1}, 2'b11);
    end
    chk("t6_wr", bus_rr.wr, 5'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
